// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared types for the reset release sequencer.
// Contents: sequencer state encoding and last-reset-cause encoding.
package reset_seq_pkg;
   typedef enum logic [1:0] {HOLD, STRETCH, RELEASE, DONE} seq_state_t;
   typedef enum logic [1:0] {CAUSE_NONE = 2'd0, CAUSE_HW = 2'd1, CAUSE_SW = 2'd2} rst_cause_t;
endpackage

// File: rtl/reset_sync_cell.sv
// reset_sync_cell: async-assert, sync-deassert reset synchronizer chain.
// Ports: target_clk - domain clock; source_rst - async active-high reset in;
//        sync_rst - reset out, asserts immediately, deasserts DEPTH edges after source_rst drops.
module reset_sync_cell #(
   parameter int DEPTH = 2
) (
   input  logic target_clk,
   input  logic source_rst,
   output logic sync_rst
);
   logic [DEPTH-1:0] chain;
   always_ff @(posedge target_clk or posedge source_rst)
      if (source_rst) chain <= '1;
      else chain <= chain << 1;
   assign sync_rst = chain[DEPTH-1];
endmodule

// File: rtl/reset_release_sequencer.sv
// reset_release_sequencer: multi-channel reset generator with stretched, staggered release.
// Ports: target_clk - domain clock; source_rst - async active-high reset;
//        sw_rst_req - single-cycle software reset request; target_rst - per-channel reset,
//        bit 0 released first; all_released - every channel deasserted; busy - sequence running;
//        rst_cause - last reset cause (01 hardware, 10 software), only with RESET_SEQ_CAUSE_EN.
module reset_release_sequencer
   import reset_seq_pkg::*;
#(
   parameter int CHANNELS       = 4,
   parameter int SYNC_DEPTH     = 3,
   parameter int STRETCH_CYCLES = 16,
   parameter int STAGGER_CYCLES = 8
) (
   input  logic                target_clk,
   input  logic                source_rst,
   input  logic                sw_rst_req,
   output logic [CHANNELS-1:0] target_rst,
   output logic                all_released,
   output logic                busy
`ifdef RESET_SEQ_CAUSE_EN
   ,
   output logic [1:0]          rst_cause
`endif
);
   localparam int CNT_W = $clog2((STRETCH_CYCLES > STAGGER_CYCLES ? STRETCH_CYCLES : STAGGER_CYCLES) + 1);
   localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(STRETCH_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(STAGGER_CYCLES - 1);

   seq_state_t          state, state_d;
   logic [CNT_W-1:0]    cnt, cnt_d;
   logic [CHANNELS-1:0] target_rst_d, shifted;
   logic                sync_rst, sw_accept;

   // The HOLD state register acts as the final synchronizer flop, so the
   // chain plus that register gives SYNC_DEPTH flops of deassert synchronization.
   reset_sync_cell #(.DEPTH(SYNC_DEPTH - 1)) u_sync (
      .target_clk(target_clk),
      .source_rst(source_rst),
      .sync_rst  (sync_rst)
   );

   assign sw_accept = sw_rst_req && state != HOLD;
   // Releasing channels in ascending order is a left shift of the reset vector.
   assign shifted = target_rst << 1;

   always_ff @(posedge target_clk or posedge source_rst)
      if (source_rst) begin
         state      <= HOLD;
         cnt        <= '0;
         target_rst <= '1;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         target_rst <= target_rst_d;
      end

   always_comb begin
      state_d      = state;
      cnt_d        = cnt;
      target_rst_d = target_rst;
      if (sw_accept) begin
         state_d      = STRETCH;
         cnt_d        = STRETCH_LOAD;
         target_rst_d = '1;
      end else if (state == HOLD) begin
         state_d = sync_rst ? HOLD : STRETCH;
         cnt_d   = sync_rst ? cnt : STRETCH_LOAD;
      end else if (state != DONE) begin
         if (cnt == '0) begin
            target_rst_d = shifted;
            cnt_d        = STAGGER_LOAD;
            state_d      = shifted == '0 ? DONE : RELEASE;
         end else begin
            cnt_d = cnt - CNT_W'(1);
         end
      end
   end

   always_comb begin
      busy         = state != DONE;
      all_released = state == DONE;
   end

`ifdef RESET_SEQ_CAUSE_EN
   always_ff @(posedge target_clk or posedge source_rst)
      if (source_rst) rst_cause <= CAUSE_HW;
      else if (sw_accept) rst_cause <= CAUSE_SW;
`endif
endmodule
